lru_ui_ctrl: RTL

Front-end controller for the board UI.
- Debounces the five push buttons and holds the display/operating mode.
- Converts button presses into single-cycle set/reset strobes for the event counter and the 8-entry LRU buffer.
- In read mode it provides the buffer index to display: either manual from the switches, or auto-scanned over the occupied entries.
- Sits between the raw button/switch pins and the ev_counter / buffer_lru instances, replacing their ad-hoc level-based gating.

---
 rtl/lru_ui_pkg.sv | 36 +++
 rtl/lru_ui_ctrl_debounce.sv | 42 ++++
 rtl/lru_ui_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lru_ui_pkg.sv
// Shared definitions for the board UI controller: mode encodings, buffer geometry
// and the cyclic search used by the auto-scan engine.
package lru_ui_pkg;

  localparam int BUF_DEPTH = 8;
  localparam int IDX_W     = 3;

  // One-hot mode codes, also consumed directly by the display mux.
  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_CNT    = 3'b100,
    MODE_LRU_WR = 3'b010,
    MODE_LRU_RD = 3'b001
  } mode_e;

  // Next occupied slot after ptr, wrapping 7->0; ptr itself is tried last.
  function automatic logic [IDX_W-1:0] next_occupied(
    input logic [IDX_W-1:0]     ptr,
    input logic [BUF_DEPTH-1:0] pres
  );
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] res;
    logic             found;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= BUF_DEPTH; k++) begin
      cand = ptr + k[IDX_W-1:0];
      if (!found && pres[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lru_ui_ctrl_debounce.sv
// Per-button debouncer: a level is accepted after DEBOUNCE_CYCLES consecutive
// differing samples; press_o flags the rising edge of the accepted level.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  logic [15:0] r_cnt;
  logic        r_level;
  logic        r_level_d;
  logic        w_diff;

  assign w_diff = raw_i ^ r_level;

  // raw_i is taken as already synchronous to clk_i; any mismatch run restarts on agreement.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt     <= 16'd0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (!w_diff) begin
        r_cnt <= 16'd0;
      end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_level <= raw_i;
        r_cnt   <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign level_o = r_level;
  assign press_o = r_level & ~r_level_d;

endmodule

// File: rtl/lru_ui_ctrl.sv
// UI front end: debounced buttons drive the mode FSM, one-cycle strobes to the
// event counter / LRU buffer, and the read-mode index (manual or auto-scan).
module lru_ui_ctrl
  import lru_ui_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] SCAN_PERIOD     = 32'd100000000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 btnu_i,
  input  logic                 btnl_i,
  input  logic                 btnr_i,
  input  logic                 btnd_i,
  input  logic                 btnc_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [BUF_DEPTH-1:0] buf_pres_i,
  output logic [2:0]           mode_o,
  output logic                 evc_set_o,
  output logic                 evc_rst_o,
  output logic                 lru_set_o,
  output logic                 lru_rst_o,
  output logic [IDX_W-1:0]     rd_idx_o,
  output logic                 scan_o,
  output logic                 empty_o
);

  // Bit order: u, l, r, d, c
  logic [4:0] w_raw;
  logic [4:0] w_level;
  logic [4:0] w_press;
  logic       w_unused_levels;

  assign w_raw = {btnu_i, btnl_i, btnr_i, btnd_i, btnc_i};

  for (genvar g = 0; g < 5; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .raw_i  (w_raw[g]),
      .level_o(w_level[g]),
      .press_o(w_press[g])
    );
  end

  assign w_unused_levels = ^w_level;

  logic w_press_u, w_press_l, w_press_r, w_press_d, w_press_c;
  assign {w_press_u, w_press_l, w_press_r, w_press_d, w_press_c} = w_press;

  logic w_act_c;
  logic w_act_d;
  assign w_act_d = w_press_d;
  assign w_act_c = w_press_c & ~w_press_d;

  mode_e r_mode;
  mode_e w_mode_nxt;
  logic  w_mode_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_mode <= MODE_IDLE;
    else          r_mode <= w_mode_nxt;
  end

  // Simultaneous mode presses are ambiguous and therefore dropped.
  always_comb begin
    w_mode_nxt = r_mode;
    w_mode_hit = 1'b0;
    case ({w_press_u, w_press_l, w_press_r})
      3'b100: begin w_mode_nxt = MODE_CNT;    w_mode_hit = 1'b1; end
      3'b010: begin w_mode_nxt = MODE_LRU_WR; w_mode_hit = 1'b1; end
      3'b001: begin w_mode_nxt = MODE_LRU_RD; w_mode_hit = 1'b1; end
      default: ;
    endcase
  end

  logic w_in_cnt, w_in_wr, w_in_rd;
  assign w_in_cnt = (r_mode == MODE_CNT);
  assign w_in_wr  = (r_mode == MODE_LRU_WR);
  assign w_in_rd  = (r_mode == MODE_LRU_RD);

  logic r_evc_set, r_evc_rst, r_lru_set, r_lru_rst;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_evc_set <= 1'b0;
      r_evc_rst <= 1'b0;
      r_lru_set <= 1'b0;
      r_lru_rst <= 1'b0;
    end else begin
      r_evc_set <= w_in_cnt & w_act_c;
      r_evc_rst <= w_in_cnt & w_act_d;
      r_lru_set <= w_in_wr  & w_act_c;
      r_lru_rst <= (w_in_wr | w_in_rd) & w_act_d;
    end
  end

  logic             r_scan;
  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      r_per_cnt;

  // Actions see the old mode; a mode entry in the same cycle still forces scan off.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_scan    <= 1'b0;
      r_ptr     <= '0;
      r_per_cnt <= 32'd0;
    end else begin
      if (w_in_rd && w_act_d) begin
        r_scan <= 1'b0;
        r_ptr  <= '0;
      end else if (w_in_rd && w_act_c) begin
        if (r_scan) begin
          r_scan <= 1'b0;
        end else begin
          r_scan    <= 1'b1;
          r_ptr     <= idx_i;
          r_per_cnt <= 32'd0;
        end
      end else if (r_scan) begin
        if (r_per_cnt == SCAN_PERIOD - 32'd1) begin
          r_per_cnt <= 32'd0;
          r_ptr     <= next_occupied(r_ptr, buf_pres_i);
        end else begin
          r_per_cnt <= r_per_cnt + 32'd1;
        end
      end
      if (w_mode_hit) r_scan <= 1'b0;
    end
  end

  assign mode_o    = r_mode;
  assign evc_set_o = r_evc_set;
  assign evc_rst_o = r_evc_rst;
  assign lru_set_o = r_lru_set;
  assign lru_rst_o = r_lru_rst;
  assign scan_o    = r_scan;
  assign rd_idx_o  = r_scan ? r_ptr : idx_i;
  assign empty_o   = (buf_pres_i == '0);

endmodule
